// File: rtl/pla_sweep_sequencer.sv
// pla_sweep_sequencer
// Exhaustive sweep driver for a single-output PLA netlist under test.
// Presents every N_IN-bit input vector in ascending order. Each y_in sample
// is tagged by a PIPE_LAT-deep valid pipe. The block accumulates the onset
// size and a Galois MISR signature over the sampled outputs.
// Optional feature: define PLA_SWEEP_FIRST_HIT_EN to add first_hit/hit_valid.
// These report the lowest vector that produced y_in=1.
module pla_sweep_sequencer #(
    parameter int               N_IN     = 15,
    parameter int               PIPE_LAT = 0,
    parameter int               CNT_W    = N_IN + 1,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  x_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_count,
    output logic [SIG_W-1:0] signature
`ifdef PLA_SWEEP_FIRST_HIT_EN
    ,
    output logic [N_IN-1:0]  first_hit,
    output logic             hit_valid
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Drain counter must be at least one bit wide even for a combinational FUT
    localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    x_q, x_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [CNT_W-1:0]   onset_q, onset_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               start_sweep;
    logic               samp_vld;
    logic               samp_en;
`ifdef PLA_SWEEP_FIRST_HIT_EN
    logic [N_IN-1:0]    samp_vec;
    logic [N_IN-1:0]    first_hit_q;
    logic               hit_valid_q;
`endif

    // Next-state, vector counter and drain counter; abort overrides everything
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        drain_d     = drain_q;
        start_sweep = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_SWEEP;
                        x_d         = '0;
                        start_sweep = 1'b1;
                    end
                end
                S_SWEEP: begin
                    // x_out parks on all-ones rather than wrapping
                    if (x_q == {N_IN{1'b1}}) begin
                        state_d = (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
                        drain_d = '0;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DW'(PIPE_LAT - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sample qualification: the vector presented PIPE_LAT cycles ago
    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign samp_vld = (state_q == S_SWEEP);
`ifdef PLA_SWEEP_FIRST_HIT_EN
            assign samp_vec = x_q;
`endif
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] vld_q;

            // Valid tags shift one stage per cycle; abort flushes the pipe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                end else if (abort) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= PIPE_LAT'({vld_q, (state_q == S_SWEEP)});
                end
            end
            assign samp_vld = vld_q[PIPE_LAT-1];

`ifdef PLA_SWEEP_FIRST_HIT_EN
            logic [PIPE_LAT-1:0][N_IN-1:0] tag_q;

            // Vector tags travel alongside the valid bits
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_q <= '0;
                end else begin
                    tag_q <= (PIPE_LAT * N_IN)'({tag_q, x_q});
                end
            end
            assign samp_vec = tag_q[PIPE_LAT-1];
`endif
        end
    endgenerate

    // The edge that aborts takes no sample, so partial results stop at the last whole cycle
    assign samp_en = samp_vld & ~abort;

    // Onset counter and MISR update
    always_comb begin
        onset_d = onset_q;
        sig_d   = sig_q;
        if (start_sweep) begin
            onset_d = '0;
            sig_d   = SIG_SEED;
        end else if (samp_en) begin
            onset_d = onset_q + CNT_W'(y_in);
            sig_d   = {sig_q[SIG_W-2:0], 1'b0}
                      ^ ((sig_q[SIG_W-1] ^ y_in) ? SIG_POLY : '0);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            drain_q <= '0;
            onset_q <= '0;
            sig_q   <= SIG_SEED;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            drain_q <= drain_d;
            onset_q <= onset_d;
            sig_q   <= sig_d;
        end
    end

`ifdef PLA_SWEEP_FIRST_HIT_EN
    // Vectors arrive in ascending order, so the first hit is also the lowest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_hit_q <= '0;
            hit_valid_q <= 1'b0;
        end else if (abort || start_sweep) begin
            first_hit_q <= '0;
            hit_valid_q <= 1'b0;
        end else if (samp_en && y_in && !hit_valid_q) begin
            first_hit_q <= samp_vec;
            hit_valid_q <= 1'b1;
        end
    end
    assign first_hit = first_hit_q;
    assign hit_valid = hit_valid_q;
`endif

    assign x_out       = x_q;
    assign busy        = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign onset_count = onset_q;
    assign signature   = sig_q;

endmodule

// File: tb/tb_pla_sweep_sequencer.sv
// Self-checking bench for pla_sweep_sequencer (reduced N_IN, 2-stage FUT).
// If PLA_SWEEP_FIRST_HIT_EN is defined, the first_hit and hit_valid ports are also connected and checked.
module tb_pla_sweep_sequencer;

    localparam int               N_IN = 8;
    localparam int               PL   = 2;
    localparam int               NV   = 1 << N_IN;
    localparam int               CW   = N_IN + 1;
    localparam logic [15:0]      POLY = 16'h1021;
    localparam logic [15:0]      SEED = 16'h5A5A;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [N_IN-1:0] x_out;
    logic            y_in;
    logic            busy;
    logic            done;
    logic [CW-1:0]   onset_count;
    logic [15:0]     signature;
`ifdef PLA_SWEEP_FIRST_HIT_EN
    logic [N_IN-1:0] first_hit;
    logic            hit_valid;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    int        mode = 0;
    bit        truth [NV];
    logic [N_IN-1:0] x_d1 = '0;
    logic [N_IN-1:0] x_d2 = '0;

    pla_sweep_sequencer #(
        .N_IN     (N_IN),
        .PIPE_LAT (PL),
        .CNT_W    (CW),
        .SIG_W    (16),
        .SIG_POLY (POLY),
        .SIG_SEED (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .x_out       (x_out),
        .y_in        (y_in),
        .busy        (busy),
        .done        (done),
        .onset_count (onset_count),
        .signature   (signature)
`ifdef PLA_SWEEP_FIRST_HIT_EN
        ,
        .first_hit   (first_hit),
        .hit_valid   (hit_valid)
`endif
    );

    always #5 clk = ~clk;

    // Two-stage registered FUT: y_in reflects the vector from two cycles ago
    always @(posedge clk) begin
        x_d1 <= x_out;
        x_d2 <= x_d1;
    end

    always_comb begin
        y_in = 1'b0;
        case (mode)
            1:       y_in = 1'b1;
            2:       y_in = x_d2[0];
            3:       y_in = truth[x_d2];
            4:       y_in = (x_d2 == 8'h34);
            default: y_in = 1'b0;
        endcase
    end

    // Reference function of the netlist under test, indexed by vector value
    function automatic bit fut(input int m, input int v);
        case (m)
            1:       return 1'b1;
            2:       return v[0];
            3:       return truth[v];
            4:       return (v == 'h34);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_onset(input int m, input int nvec);
        int s = 0;
        for (int v = 0; v < nvec; v++) s += int'(fut(m, v));
        return s;
    endfunction

    function automatic logic [15:0] model_sig(input int m, input int nvec);
        logic [15:0] s = SEED;
        bit fb;
        for (int v = 0; v < nvec; v++) begin
            fb = s[15] ^ fut(m, v);
            s  = {s[14:0], 1'b0};
            if (fb) s = s ^ POLY;
        end
        return s;
    endfunction

    function automatic int model_first(input int m);
        for (int v = 0; v < NV; v++) if (fut(m, v)) return v;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests_run++;
        assert (obs === req)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    // One full sweep; optional extra start pulse at cycle extra_start while busy
    task automatic run_sweep(input int m, input int extra_start);
        int n;
        int busy_n;
        int fh;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("first_vector", 32'(x_out), 32'd0);
        n = 1;
        busy_n = 0;
        while (done !== 1'b1 && n < 2000) begin
            if (busy === 1'b1) busy_n++;
            if (n == extra_start) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        chk("done_cycle", 32'(n), 32'(NV + PL + 1));
        chk("busy_cycles", 32'(busy_n), 32'(NV + PL));
        chk("onset", 32'(onset_count), 32'(model_onset(m, NV)));
        chk("signature", 32'(signature), 32'(model_sig(m, NV)));
        chk("x_hold", 32'(x_out), 32'(NV - 1));
`ifdef PLA_SWEEP_FIRST_HIT_EN
        fh = model_first(m);
        chk("hit_valid", 32'(hit_valid), (fh >= 0) ? 32'd1 : 32'd0);
        chk("first_hit", 32'(first_hit), (fh >= 0) ? 32'(fh) : 32'd0);
`else
        fh = model_first(m);
`endif
        $display("[TB] sweep mode=%0d done_cycle=%0d onset=%0d sig=%04h first=%0d",
                 m, n, onset_count, signature, fh);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nsamp;
        logic [CW-1:0] held;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < NV; i++) truth[i] = 1'($urandom_range(0, 1));

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_onset", 32'(onset_count), 32'd0);
        chk("rst_sig", 32'(signature), 32'(SEED));
        $display("[TB] reset checked");
        @(negedge clk);
        rst = 1'b0;

        // Constant 0, constant 1, y=x0 through the 2-stage FUT, random netlist with stray start
        run_sweep(0, 0);
        run_sweep(1, 0);
        run_sweep(2, 0);
        run_sweep(3, 50);

        // Abort in cycle 100 of a sweep with y_in=1
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_pre_x", 32'(x_out), 32'd99);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        nsamp = 100 - 1 - PL;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_x", 32'(x_out), 32'd99);
        chk("abort_onset", 32'(onset_count), 32'(model_onset(1, nsamp)));
        chk("abort_sig", 32'(signature), 32'(model_sig(1, nsamp)));
        repeat (4) @(posedge clk);
        #1;
        chk("abort_frozen_onset", 32'(onset_count), 32'(model_onset(1, nsamp)));
        chk("abort_frozen_x", 32'(x_out), 32'd99);
        $display("[TB] abort at cycle 100 onset=%0d x_out=%0d", onset_count, x_out);
        run_sweep(1, 0);

        // start together with abort while in DONE: abort wins, no restart
        held = onset_count;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_done", 32'(done), 32'd0);
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_onset", 32'(onset_count), 32'(held));
        @(posedge clk);
        #1;
        chk("sa_no_restart", 32'(busy), 32'd0);
        chk("sa_x", 32'(x_out), 32'(NV - 1));
        $display("[TB] start+abort in DONE busy=%0b done=%0b", busy, done);

        // Asynchronous reset mid-sweep
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_x_out", 32'(x_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_onset", 32'(onset_count), 32'd0);
        chk("arst_sig", 32'(signature), 32'(SEED));
        $display("[TB] async reset mid-sweep x_out=%0d busy=%0b", x_out, busy);
        @(negedge clk);
        rst = 1'b0;

        // Single-minterm netlist
        run_sweep(4, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
